// File: rtl/iq_window_pkg.sv
// Shared constants and helpers for the I/Q sliding window.
// IQ_WINDOW_ENERGY_EN enables the running L1-energy accumulator.
package iq_window_pkg;

    localparam int IQW_DATA_W = 16;
    localparam int IQW_DEPTH  = 16;
    localparam int IQW_STRIDE = 1;

    function automatic int energy_w(input int dw, input int depth);
        return dw + 1 + $clog2(depth);
    endfunction

    // Callers sign-extend to 32 bits; valid for sample widths up to 31.
    function automatic logic [32:0] mag_l1(
        input logic signed [31:0] i,
        input logic signed [31:0] q
    );
        logic [31:0] ai;
        logic [31:0] aq;
        ai = i[31] ? 32'(-i) : 32'(i);
        aq = q[31] ? 32'(-q) : 32'(q);
        return {1'b0, ai} + {1'b0, aq};
    endfunction

endpackage

// File: rtl/iq_window_ctrl.sv
// Fill counter, stride counter, win_full and win_valid generation.
// Shared by both energy and non-energy builds.
module iq_window_ctrl
    import iq_window_pkg::*;
#(
    parameter int DEPTH  = IQW_DEPTH,
    parameter int STRIDE = IQW_STRIDE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_en,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         win_full,
    output logic                         win_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STRIDE + 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(DEPTH - 1);
    localparam logic [SW-1:0] STR_LAST  = SW'(STRIDE - 1);

    logic [CW-1:0] fill_q, fill_d;
    logic [SW-1:0] stride_q, stride_d;
    logic          full_q, full_d;
    logic          valid_q, valid_d;

    always_comb begin
        fill_d   = fill_q;
        stride_d = stride_q;
        full_d   = full_q;
        valid_d  = 1'b0;
        if (flush) begin
            fill_d   = '0;
            stride_d = '0;
            full_d   = 1'b0;
        end else if (in_en) begin
            if (!full_q) begin
                fill_d   = fill_q + CW'(1);
                stride_d = '0;
                if (fill_q == FILL_LAST) begin
                    full_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end else if (stride_q == STR_LAST) begin
                stride_d = '0;
                valid_d  = 1'b1;
            end else begin
                stride_d = stride_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q   <= '0;
            stride_q <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            stride_q <= stride_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
        end
    end

    assign fill_cnt  = fill_q;
    assign win_full  = full_q;
    assign win_valid = valid_q;

endmodule

// File: rtl/iq_window_shift.sv
// Sliding window of the latest DEPTH I/Q samples for the UW correlator.
// IQ_WINDOW_ENERGY_EN adds the energy port and accumulator.
module iq_window_shift
    import iq_window_pkg::*;
#(
    parameter int DATA_W = IQW_DATA_W,
    parameter int DEPTH  = IQW_DEPTH,
    parameter int STRIDE = IQW_STRIDE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_en,
    input  logic signed [DATA_W-1:0]          in_i,
    input  logic signed [DATA_W-1:0]          in_q,
    input  logic                              flush,
    output logic [DEPTH*DATA_W-1:0]           win_i,
    output logic [DEPTH*DATA_W-1:0]           win_q,
    output logic [$clog2(DEPTH+1)-1:0]        fill_cnt,
    output logic                              win_full,
    output logic                              win_valid
`ifdef IQ_WINDOW_ENERGY_EN
    ,
    output logic [energy_w(DATA_W, DEPTH)-1:0] energy
`endif
);

    logic [DEPTH-1:0][DATA_W-1:0] slot_i_q, slot_i_d;
    logic [DEPTH-1:0][DATA_W-1:0] slot_q_q, slot_q_d;

    // Slot 0 is the oldest; new samples enter at the top.
    always_comb begin
        slot_i_d = slot_i_q;
        slot_q_d = slot_q_q;
        if (flush) begin
            slot_i_d = '0;
            slot_q_d = '0;
        end else if (in_en) begin
            slot_i_d = {in_i, slot_i_q[DEPTH-1:1]};
            slot_q_d = {in_q, slot_q_q[DEPTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_i_q <= '0;
            slot_q_q <= '0;
        end else begin
            slot_i_q <= slot_i_d;
            slot_q_q <= slot_q_d;
        end
    end

    assign win_i = slot_i_q;
    assign win_q = slot_q_q;

    iq_window_ctrl #(
        .DEPTH  (DEPTH),
        .STRIDE (STRIDE)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .flush     (flush),
        .fill_cnt  (fill_cnt),
        .win_full  (win_full),
        .win_valid (win_valid)
    );

`ifdef IQ_WINDOW_ENERGY_EN
    localparam int EW = energy_w(DATA_W, DEPTH);
    localparam int MW = DATA_W + 1;

    logic [32:0]   mag_new_full, mag_old_full;
    logic [MW-1:0] mag_new, mag_old;
    logic [EW-1:0] energy_q, energy_d;
    logic          unused_mag;

    assign mag_new_full = mag_l1(32'(in_i), 32'(in_q));
    assign mag_old_full = mag_l1(32'($signed(slot_i_q[0])),
                                 32'($signed(slot_q_q[0])));
    assign mag_new    = mag_new_full[MW-1:0];
    assign mag_old    = mag_old_full[MW-1:0];
    assign unused_mag = ^{mag_new_full[32:MW], mag_old_full[32:MW]};

    // Outgoing slot 0 is zero until full, so the subtraction is exact.
    always_comb begin
        energy_d = energy_q;
        if (flush) begin
            energy_d = '0;
        end else if (in_en) begin
            energy_d = energy_q
                     + {{(EW-MW){1'b0}}, mag_new}
                     - {{(EW-MW){1'b0}}, mag_old};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            energy_q <= '0;
        end else begin
            energy_q <= energy_d;
        end
    end

    assign energy = energy_q;
`endif

endmodule

// File: tb/tb_iq_window_shift.sv
// Directed bench: two instances (STRIDE 1 and 4) fed the same stimulus.
// Energy checks compile in with IQ_WINDOW_ENERGY_EN.
module tb_iq_window_shift;

    localparam int DW = 16;
    localparam int DP = 16;

    logic clk = 1'b0;
    logic rst;
    logic in_en;
    logic flush;
    logic signed [DW-1:0] di;
    logic signed [DW-1:0] dq;

    logic [DP*DW-1:0] wi_a, wq_a, wi_b, wq_b;
    logic [4:0]       fill_a, fill_b;
    logic             full_a, full_b, valid_a, valid_b;
`ifdef IQ_WINDOW_ENERGY_EN
    logic [20:0]      en_a, en_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iq_window_shift #(.DATA_W(DW), .DEPTH(DP), .STRIDE(1)) u_a (
        .clk(clk), .rst(rst), .in_en(in_en), .in_i(di), .in_q(dq),
        .flush(flush), .win_i(wi_a), .win_q(wq_a), .fill_cnt(fill_a),
        .win_full(full_a), .win_valid(valid_a)
`ifdef IQ_WINDOW_ENERGY_EN
        , .energy(en_a)
`endif
    );

    iq_window_shift #(.DATA_W(DW), .DEPTH(DP), .STRIDE(4)) u_b (
        .clk(clk), .rst(rst), .in_en(in_en), .in_i(di), .in_q(dq),
        .flush(flush), .win_i(wi_b), .win_q(wq_b), .fill_cnt(fill_b),
        .win_full(full_b), .win_valid(valid_b)
`ifdef IQ_WINDOW_ENERGY_EN
        , .energy(en_b)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input int vi, input int vq,
                        input logic fl);
        in_en = en;
        di    = DW'(vi);
        dq    = DW'(vq);
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_en = 1'b0; flush = 1'b0; di = '0; dq = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_fill", fill_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_win", wi_a | wq_a, 0);

        // Fill with 1..16 (q = -i)
        for (int v = 1; v <= 16; v++) begin
            step(1, v, -v, 0);
            chk($sformatf("fill_a_%0d", v), fill_a, v);
            chk($sformatf("valid_a_%0d", v), valid_a, v == 16);
            chk($sformatf("valid_b_%0d", v), valid_b, v == 16);
            chk($sformatf("full_a_%0d", v), full_a, v == 16);
        end
        chk("slot0_i", wi_a[0 +: DW], 1);
        chk("slot15_i", wi_a[15*DW +: DW], 16);
        chk("slot15_q", wq_a[15*DW +: DW], 16'hFFF0);
        chk("full_b", full_b, 1);
`ifdef IQ_WINDOW_ENERGY_EN
        chk("energy_fill", en_a, 272);
`endif

        // Accepts 17..19 with idle gaps, then 20
        for (int v = 17; v <= 19; v++) begin
            step(1, v, -v, 0);
            chk($sformatf("stride_a_%0d", v), valid_a, 1);
            chk($sformatf("stride_b_%0d", v), valid_b, 0);
            step(0, 0, 0, 0);
            chk($sformatf("idle_a_%0d", v), valid_a, 0);
            chk($sformatf("idle_b_%0d", v), valid_b, 0);
        end
        step(1, 20, -20, 0);
        chk("stride_b_20", valid_b, 1);
        chk("stride_a_20", valid_a, 1);
        chk("slot0_after20", wi_a[0 +: DW], 5);
        chk("fill_sat", fill_a, 16);
        step(1, 21, -21, 0);
        chk("stride_b_21", valid_b, 0);
`ifdef IQ_WINDOW_ENERGY_EN
        chk("energy_slide", en_a, 2 * (6 + 21) * 16 / 2);
`endif

        // Flush with a sample present
        step(1, 99, 99, 1);
        chk("flush_fill", fill_a, 0);
        chk("flush_full", full_a, 0);
        chk("flush_valid", valid_a, 0);
        chk("flush_win", {wi_a, wq_a, wi_b, wq_b}, 0);
`ifdef IQ_WINDOW_ENERGY_EN
        chk("flush_energy", en_a, 0);
`endif

        // Mid-fill reset with in_en high
        for (int v = 1; v <= 7; v++) step(1, v, v, 0);
        chk("midfill_7", fill_a, 7);
        rst = 1'b1;
        step(1, 55, 55, 0);
        rst = 1'b0;
        chk("rst_mid_fill", {fill_a, fill_b}, 0);
        chk("rst_mid_win", {wi_a, wq_a}, 0);
        chk("rst_mid_full", {full_a, valid_a}, 0);

        // Restarted fill: first strobe after 16 accepts
        for (int v = 1; v <= 16; v++) begin
            step(1, v + 100, v, 0);
            chk($sformatf("refill_b_%0d", v), valid_b, v == 16);
        end
        chk("refill_slot0", wi_b[0 +: DW], 101);

`ifdef IQ_WINDOW_ENERGY_EN
        step(0, 0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            step(1, -32768, 32767, 0);
            chk($sformatf("en_max_%0d", k), en_a,
                (k < 16 ? k : 16) * 65535);
        end
        step(0, 0, 0, 1);
        for (int k = 1; k <= 16; k++) step(1, 1, -1, 0);
        chk("en_ones", en_b, 32);
        for (int k = 1; k <= 16; k++) begin
            step(1, 0, 0, 0);
            chk($sformatf("en_drain_%0d", k), en_b, 32 - 2 * k);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_window_shift.md
# iq_window_shift

Parametrised sliding window for complex I/Q samples. It holds the most recent DEPTH samples, tracks how full the window is, and pulses a window-valid strobe every STRIDE accepted samples once the window is full. An optional running L1-energy accumulator can be compiled in. It sits between the sample front end and the unique-word correlator, which consumes the full window in parallel on each strobe.

## Interface
- DATA_W, 16, width of each signed I and Q sample
- DEPTH, 16, window length in samples (≥2)
- STRIDE, 1, accepted samples between win_valid pulses once full (1..DEPTH)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_en  in  1  accept in_i/in_q this cycle
- in_i, in_q  in  DATA_W  signed sample
- flush  in  1  synchronous clear of window contents and status
- win_i, win_q  out  DEPTH*DATA_W  flat window; slot k at bits [k*DATA_W +: DATA_W]; slot 0 oldest, slot DEPTH-1 newest
- fill_cnt  out  $clog2(DEPTH+1)  samples held, saturates at DEPTH
- win_full  out  1  fill_cnt == DEPTH (registered)
- win_valid  out  1  one-cycle strobe: window content is a fresh evaluation point
- energy  out  DATA_W+1+$clog2(DEPTH)  unsigned sum of |i|+|q| over all slots (present only with IQ_WINDOW_ENERGY_EN)

## Operation
- Reset or flush: all slots 0, fill_cnt 0, win_full 0, win_valid 0, stride counter 0, energy 0.
- Accept (in_en=1, flush=0): slot k ← slot k+1 for k<DEPTH-1; slot DEPTH-1 ← input.
- Accept: fill_cnt ← min(fill_cnt+1, DEPTH).
- Not accepting: all state holds and win_valid=0.
- Stride counter counts only accepted samples while already full; it is held at 0 while not full.
- win_valid=1 on the accept that brings fill_cnt to DEPTH. The stride counter is 0 after that accept.
- Each later accept increments the stride counter. When the increment would reach STRIDE, win_valid=1 and the counter returns to 0.
- STRIDE=1: win_valid follows every accept once full.
- Priority: rst > flush > in_en. A sample presented with flush is discarded.
- Energy: energy ← energy + mag(new) − mag(slot 0), where mag(x) = |x_i|+|x_q|.
  - |−2^(DATA_W−1)| = 2^(DATA_W−1) exactly; no saturation is needed at this width.
  - Before the window is full, slot 0 is zero, so the subtraction is exact.
  - The accumulator never underflows or overflows.

## Timing
- All outputs are registered and update on the clk edge that samples in_en=1.
- Latency is 1 cycle: input at edge n appears in slot DEPTH-1 and in energy after edge n.
- win_valid is high for exactly the cycle after the qualifying edge, coincident with the updated window.
- Back-to-back in_en every cycle is supported; there is no backpressure.
- flush or rst mid-fill or mid-stride restarts the fill sequence; the first win_valid comes DEPTH accepts later.

## Configuration
- IQ_WINDOW_ENERGY_EN defined: energy port present, plus the accumulator and mag logic.
- Undefined: energy port absent and no accumulator logic; all other behaviour is identical.

## Structure
- Package iq_window_pkg holds:
  - mag_l1 function (sign-extended abs, DATA_W+1 result)
  - energy-width constant function
  - default DATA_W/DEPTH/STRIDE localparams
- Sub-module iq_window_ctrl holds the fill counter, stride counter, win_full and win_valid generation. The top level holds the slot registers and energy.

## Test plan
- rst, then 16 accepts of values 1..16 (DEPTH=16, STRIDE=1) -> fill_cnt 1..16; win_valid first high after accept 16; slot 0=1, slot 15=16; win_full=1.
- Continue with 3 more accepts (17, 18, 19) with idle gaps, STRIDE=4 build -> win_valid stays 0 (counter 1..3); the 4th later accept pulses win_valid once.
- Full window, flush together with in_en (value 99) -> all slots 0, fill_cnt 0, win_full 0; 99 absent from the window.
- ENERGY build: feed i=−32768, q=32767 repeatedly -> energy grows by 65535 per accept up to 16×65535=1048560, then stays constant.
- ENERGY build: full window of (1,−1) followed by (0,0) accepts -> energy drops by 2 per accept to 0.
- rst asserted for one cycle mid-fill (fill_cnt=7) with in_en high -> all outputs 0 the next cycle; sample discarded.
